// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, control-register bit positions and frame constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam int CTRL_SEND_BIT    = 0;
    localparam int CTRL_NEW_RX_BIT  = 1;
    localparam int DEFAULT_BAUD_DIV = 868;
    localparam int FRAME_BITS       = 10;

    function automatic logic [31:0] clear_send(input logic [31:0] ctrl);
        clear_send = ctrl & ~(32'd1 << CTRL_SEND_BIT);
    endfunction

endpackage

// File: rtl/module_uart_baud_counter.sv
// module_uart_baud_counter: counts 0..BAUD_DIV-1 and ticks for one cycle on the last count
module module_uart_baud_counter
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    logic [15:0] r_count;

    assign tick_o = (r_count == 16'(BAUD_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || tick_o)
            r_count <= 16'd0;
        else
            r_count <= r_count + 16'd1;
    end

endmodule

// File: rtl/module_fsm_uart_tx.sv
// module_fsm_uart_tx: 8N1 UART transmitter FSM that clears the SEND bit of the control register when a frame completes
module module_fsm_uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ctrl_i,
    input  logic [31:0] data_tx_i,
    output logic        tx_o,
    output logic        we_fsm_o,
    output logic [31:0] instruccion_fsm_o,
    output logic        busy_o
);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    logic       r_tx;
    logic       r_we;
    logic       r_busy;
    logic       w_tick;
    logic       w_clear;
    logic       w_unused_data;

    assign w_clear           = (r_state == ST_IDLE);
    assign w_unused_data     = ^data_tx_i[31:8];
    assign tx_o              = r_tx;
    assign we_fsm_o          = r_we;
    assign busy_o            = r_busy;
    assign instruccion_fsm_o = clear_send(ctrl_i);

    module_uart_baud_counter #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(w_clear),
        .tick_o (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_shift <= 8'd0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_i[CTRL_SEND_BIT]) begin
                        r_shift <= data_tx_i[7:0];
                        r_bit   <= 3'd0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end else begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                        r_tx    <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
                        r_state <= (r_bit == 3'd7) ? ST_STOP : ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_we    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/module_fsm_uart_tx.md
MODULE_FSM_UART_TX -- requirements
Module: module_fsm_uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 868, SHALL set clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 clk_i  input  1  system clock; single clock domain, all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 ctrl_i  input  32  current UART control register contents; bit0 = SEND request, bit1 = NEW_RX flag; bits 31:2 reserved.
REQ-005 data_tx_i  input  32  TX data register; bits 7:0 = byte to send.
REQ-006 tx_o  output  1  serial line, idle high.
REQ-007 we_fsm_o  output  1  one-cycle write strobe to the control register; has priority over processor writes.
REQ-008 instruccion_fsm_o  output  32  value the control register takes when we_fsm_o=1.
REQ-009 busy_o  output  1  high from START through DONE inclusive.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-011 IDLE: tx_o=1; if ctrl_i[0]=1 at a rising edge, SHALL latch data_tx_i[7:0] into a shift register, clear the baud and bit counters, and enter START.
REQ-012 Frame SHALL be 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1); each bit held for exactly BAUD_DIV cycles.
REQ-013 tx_o SHALL be registered; start bit appears the cycle after the edge at which IDLE sampled ctrl_i[0]=1.
REQ-014 Baud counter SHALL count 0..BAUD_DIV-1 and emit a one-cycle tick on BAUD_DIV-1, then wrap to 0; state/bit advances only on tick.
REQ-015 DATA SHALL use a 3-bit bit counter; on the tick at count 7, go to STOP; shift register shifts right once per tick.
REQ-016 STOP tick SHALL go to DONE; total START+DATA+STOP duration = 10*BAUD_DIV cycles.
REQ-017 DONE SHALL last exactly one cycle: we_fsm_o=1, instruccion_fsm_o = ctrl_i with bit0 forced to 0 (bits 31:1 passed through from that cycle's ctrl_i), then go to IDLE.
REQ-018 Outside DONE, we_fsm_o SHALL be 0 and instruccion_fsm_o SHALL equal ctrl_i & 32'hFFFF_FFFE.
REQ-019 IDLE following DONE SHALL see the cleared SEND bit (control register updates on the same edge); no retransmission without a new processor write.
REQ-020 Changes to data_tx_i or ctrl_i while busy_o=1 SHALL NOT alter the frame in flight; processor writes that re-set SEND during a frame are overwritten by DONE (request lost, by design).
REQ-021 NEW_RX and reserved bits SHALL never be modified by this block except via pass-through in REQ-017.

Reset
REQ-022 On rst_i=1 at a rising edge: state=IDLE, tx_o=1, we_fsm_o=0, busy_o=0, counters and shift register=0, regardless of state (mid-frame abort, no DONE pulse).
REQ-023 Reset SHALL take priority over every other condition, including a simultaneous SEND request.

Structure
REQ-024 Package uart_pkg SHALL hold: state enum type, CTRL_SEND_BIT=0, CTRL_NEW_RX_BIT=1, DEFAULT_BAUD_DIV=868, FRAME_BITS=10.
REQ-025 Baud timing SHALL be a sub-module module_uart_baud_counter (ports clk_i, rst_i, clear_i, tick_o; parameter BAUD_DIV), 16-bit count.
REQ-026 FSM, shift register, bit counter and output registers SHALL reside in module_fsm_uart_tx; no combinational path from ctrl_i to tx_o.

Verification (BAUD_DIV=4)
REQ-027 Reset, idle 20 cycles -> tx_o=1, we_fsm_o=0, busy_o=0 throughout.
REQ-028 data_tx_i=0x000000A5, ctrl_i=0x1 -> tx_o bit sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles; we_fsm_o single pulse 40 cycles after start-bit first cycle with instruccion_fsm_o=0x0.
REQ-029 ctrl_i=0x3, data 0xFF -> DONE writes instruccion_fsm_o=0x2 (NEW_RX preserved); no second frame after writeback.
REQ-030 data_tx_i changed to 0x00 at cycle 10 of a 0x5A frame -> line still carries 0x5A.
REQ-031 rst_i pulsed mid-DATA -> next cycle tx_o=1, busy_o=0, no we_fsm_o pulse; fresh SEND afterwards yields complete correct frame.
REQ-032 ctrl_i held 0x1 across two writebacks via a model of the control register -> exactly one frame per processor write.
